// File: rtl/clk_period_meter.sv
// Single-shot period meter: counts clk_i cycles between two synchronized rising edges of sig_i.
// Define HIGH_TIME_EN to also measure the high time within that period on high_o.
`timescale 1ns / 1ps

module clk_period_meter #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             sig_i,
    input  logic             start,
    input  logic [CNT_W-1:0] timeout_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StWaitEdge,
        StCount
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       tmo_cnt_q;
    logic                   s;
    logic                   rise;
    logic                   tmo_hit;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise    = s & ~s_d_q;
    assign tmo_hit = (timeout_i != '0) && (tmo_cnt_q == timeout_i);

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            s_d_q  <= s;
        end
    end

`ifdef HIGH_TIME_EN
    logic [CNT_W-1:0] hcnt_q;
`else
    assign high_o = '0;
`endif

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            busy_o    <= 1'b0;
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;
            period_o  <= '0;
            cnt_q     <= '0;
            tmo_cnt_q <= '0;
`ifdef HIGH_TIME_EN
            high_o    <= '0;
            hcnt_q    <= '0;
`endif
        end else begin
            // Saturating abort counter runs in every busy state.
            if (state_q != StIdle && tmo_cnt_q != CntMax) begin
                tmo_cnt_q <= tmo_cnt_q + CntOne;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StWaitEdge;
                        busy_o    <= 1'b1;
                        valid_o   <= 1'b0;
                        timeout_o <= 1'b0;
                        tmo_cnt_q <= '0;
                    end
                end
                StWaitEdge: begin
                    if (tmo_hit) begin
                        state_q   <= StIdle;
                        busy_o    <= 1'b0;
                        timeout_o <= 1'b1;
                    end else if (rise) begin
                        state_q <= StCount;
                        cnt_q   <= CntOne;
`ifdef HIGH_TIME_EN
                        hcnt_q  <= CntOne;
`endif
                    end
                end
                StCount: begin
                    // A completing edge wins over a timeout in the same cycle.
                    if (rise) begin
                        state_q  <= StIdle;
                        busy_o   <= 1'b0;
                        valid_o  <= 1'b1;
                        period_o <= cnt_q;
`ifdef HIGH_TIME_EN
                        high_o   <= hcnt_q;
`endif
                    end else if (tmo_hit) begin
                        state_q   <= StIdle;
                        busy_o    <= 1'b0;
                        timeout_o <= 1'b1;
                    end else begin
                        if (cnt_q != CntMax) begin
                            cnt_q <= cnt_q + CntOne;
                        end
`ifdef HIGH_TIME_EN
                        if (s && hcnt_q != CntMax) begin
                            hcnt_q <= hcnt_q + CntOne;
                        end
`endif
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Self-checking bench for clk_period_meter: a pattern generator drives sig_i and expected
// results come from the generator's high/low lengths and the start-relative timing rules.
`timescale 1ns / 1ps

module tb_clk_period_meter;

    localparam int unsigned CNT_W = 32;
    localparam int unsigned SYNC  = 2;

    logic             clk_i = 1'b0;
    logic             reset_n = 1'b0;
    logic             sig_i = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] timeout_i = '0;
    logic             busy_o;
    logic             valid_o;
    logic             timeout_o;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;

    int passed = 0;
    int total  = 0;

    bit gen_en = 1'b0;
    int gen_hi = 4;
    int gen_lo = 4;
    bit man_sig = 1'b0;
    int ph = 0;
    logic [CNT_W-1:0] last_period = '0;

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk_i    (clk_i),
        .reset_n  (reset_n),
        .sig_i    (sig_i),
        .start    (start),
        .timeout_i(timeout_i),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .timeout_o(timeout_o),
        .period_o (period_o),
        .high_o   (high_o)
    );

    always #5 clk_i = ~clk_i;

    // Signal source: periodic pattern (gen_hi high, gen_lo low) or a manual level.
    always @(negedge clk_i) begin
        if (gen_en) begin
            sig_i = (ph < gen_hi);
            ph = (ph + 1 >= gen_hi + gen_lo) ? 0 : ph + 1;
        end else begin
            sig_i = man_sig;
        end
    end

    function automatic logic [CNT_W-1:0] exp_high(input int hi);
`ifdef HIGH_TIME_EN
        return CNT_W'(hi);
`else
        return '0;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < limit) begin
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
            cyc++;
            tick(1);
        end
    endtask

    task automatic set_gen(input int hi, input int lo);
        gen_hi = hi;
        gen_lo = lo;
        gen_en = 1'b1;
        tick(2 * (hi + lo) + 10);
    endtask

    task automatic measure_check(input string name, input int hi, input int lo);
        int cyc;
        bit ok;
        logic [CNT_W-1:0] ep;
        ep = CNT_W'(hi + lo);
        pulse_start();
        wait_idle(3 * (hi + lo) + 20, cyc, ok);
        total++;
        if (!ok) $display("FAIL %s done: no completion within budget", name);
        else passed++;
        total++;
        if (valid_o !== 1'b1) $display("FAIL %s valid: got %b want 1", name, valid_o);
        else passed++;
        total++;
        if (timeout_o !== 1'b0) $display("FAIL %s timeout: got %b want 0", name, timeout_o);
        else passed++;
        total++;
        if (period_o !== ep) $display("FAIL %s period: got %0d want %0d", name, period_o, ep);
        else passed++;
        total++;
        if (high_o !== exp_high(hi))
            $display("FAIL %s high: got %0d want %0d", name, high_o, exp_high(hi));
        else passed++;
        last_period = ep;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        total++;
        if (busy_o !== 1'b0) $display("FAIL reset busy: got %b want 0", busy_o);
        else passed++;
        total++;
        if ({valid_o, timeout_o} !== 2'b00)
            $display("FAIL reset flags: got %b want 00", {valid_o, timeout_o});
        else passed++;
        total++;
        if (period_o !== '0 || high_o !== '0)
            $display("FAIL reset results: got %0d/%0d want 0/0", period_o, high_o);
        else passed++;
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_divider();
        int divs[3] = '{3, 0, 99};
        foreach (divs[i]) begin
            set_gen(divs[i] + 1, divs[i] + 1);
            measure_check($sformatf("div%0d", divs[i]), divs[i] + 1, divs[i] + 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            int hi = $urandom_range(25, 1);
            int lo = $urandom_range(25, 1);
            set_gen(hi, lo);
            measure_check($sformatf("rand%0d_%0dh%0dl", i, hi, lo), hi, lo);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        bit ok;
        gen_en  = 1'b0;
        man_sig = 1'b0;
        tick(10);
        timeout_i = CNT_W'(50);
        pulse_start();
        total++;
        if (valid_o !== 1'b0) $display("FAIL tmo valid_cleared: got %b want 0", valid_o);
        else passed++;
        wait_idle(200, cyc, ok);
        total++;
        if (!ok || cyc != 51) $display("FAIL tmo busy_len: got %0d want 51 (ok=%b)", cyc, ok);
        else passed++;
        total++;
        if ({timeout_o, valid_o} !== 2'b10)
            $display("FAIL tmo flags: got %b want 10", {timeout_o, valid_o});
        else passed++;
        total++;
        if (period_o !== last_period)
            $display("FAIL tmo period_kept: got %0d want %0d", period_o, last_period);
        else passed++;
        timeout_i = '0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit ok;
        set_gen(4, 4);
        pulse_start();
        tick(3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle(60, cyc, ok);
        total++;
        if (!ok || valid_o !== 1'b1 || period_o !== CNT_W'(8))
            $display("FAIL b2b result: got ok=%b valid=%b period=%0d want 1/1/8",
                     ok, valid_o, period_o);
        else passed++;
        tick(20);
        total++;
        if (busy_o !== 1'b0 || valid_o !== 1'b1)
            $display("FAIL b2b no_restart: got busy=%b valid=%b want 0/1", busy_o, valid_o);
        else passed++;
        last_period = CNT_W'(8);
    endtask

    // Rising edges sampled at start-relative edges a1 and a2 (pulse width h); the completing
    // edge acts SYNC edges later, where the abort counter equals (edge index - 1).
    task automatic run_collision(input int tmo, input bit expect_done);
        int a1 = 3;
        int h = 3;
        int a2 = 10;
        int k;
        gen_en  = 1'b0;
        man_sig = 1'b0;
        tick(10);
        timeout_i = CNT_W'(tmo);
        pulse_start();
        for (k = 0; k < 100; k++) begin
            if (!busy_o) break;
            man_sig = ((k + 1 >= a1) && (k + 1 < a1 + h)) || ((k + 1 >= a2) && (k + 1 < a2 + h));
            tick(1);
        end
        total++;
        if (k != tmo + 1) $display("FAIL coll%0d busy_len: got %0d want %0d", tmo, k, tmo + 1);
        else passed++;
        total++;
        if ({valid_o, timeout_o} !== {expect_done, !expect_done})
            $display("FAIL coll%0d flags: got %b want %b", tmo, {valid_o, timeout_o},
                     {expect_done, !expect_done});
        else passed++;
        if (expect_done) last_period = CNT_W'(a2 - a1);
        total++;
        if (period_o !== last_period)
            $display("FAIL coll%0d period: got %0d want %0d", tmo, period_o, last_period);
        else passed++;
        man_sig   = 1'b0;
        timeout_i = '0;
    endtask

    task automatic test_collision();
        run_collision(10 + SYNC - 1, 1'b1);
        run_collision(10 + SYNC - 2, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_gen(50, 50);
        pulse_start();
        tick(40);
        reset_n = 1'b0;
        tick(1);
        total++;
        if ({busy_o, valid_o, timeout_o} !== 3'b000 || period_o !== '0 || high_o !== '0)
            $display("FAIL midrst outputs: got b%b v%b t%b p%0d h%0d want all 0",
                     busy_o, valid_o, timeout_o, period_o, high_o);
        else passed++;
        reset_n = 1'b1;
        set_gen(4, 4);
        measure_check("after_reset", 4, 4);
    endtask

    initial begin
        test_reset();
        test_divider();
        test_random();
        test_timeout();
        test_back_to_back();
        test_collision();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
